spawn_ctrl: RTL

Gameplay-side controller for one obstacle channel: decides when to launch an obstacle through the spawner's `en` input and watches the obstacle it launched. It reads back the spawner's `active`/`hoffset`/`voffset` outputs, checks each cycle for overlap with the player box, and asserts the spawner's `despawn` input on a hit. It keeps the score (obstacles survived) and lives, and raises `game_over` when lives run out. It sits between the player-position logic and one spawner instance, driving the spawner's `en` and `despawn` inputs.

---
 rtl/spawn_ctrl_if.sv | 40 ++++
 rtl/spawn_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/spawn_ctrl_if.sv
// Bundle between the spawn controller, the player-position logic and one
// obstacle spawner.
//   master : the controller (drives spawn_en/despawn and the game status)
//   slave  : the surrounding logic (drives run, player position, spawner readback)
// Signals:
//   run                  game running, permits launches
//   player_h / player_v  player top-left corner (signed)
//   obj_active           spawner 'active'
//   obj_hoffset/voffset  spawner obstacle top-left corner (signed)
//   spawn_en / despawn   to spawner 'en' / 'despawn'
//   hit                  one-cycle collision pulse
//   score / lives        obstacles passed / remaining lives
//   game_over            sticky end-of-game flag
interface spawn_ctrl_if #(
  parameter int HWIDTH = 11,
  parameter int VWIDTH = 10
);
  logic                     run;
  logic signed [HWIDTH-1:0] player_h;
  logic signed [VWIDTH-1:0] player_v;
  logic                     obj_active;
  logic signed [HWIDTH-1:0] obj_hoffset;
  logic signed [VWIDTH-1:0] obj_voffset;
  logic                     spawn_en;
  logic                     despawn;
  logic                     hit;
  logic [15:0]              score;
  logic [1:0]               lives;
  logic                     game_over;

  modport master (
    input  run, player_h, player_v, obj_active, obj_hoffset, obj_voffset,
    output spawn_en, despawn, hit, score, lives, game_over
  );

  modport slave (
    output run, player_h, player_v, obj_active, obj_hoffset, obj_voffset,
    input  spawn_en, despawn, hit, score, lives, game_over
  );
endinterface

// File: rtl/spawn_ctrl.sv
// Gameplay controller for one obstacle channel. Launches an obstacle after a
// pseudo-random gap, watches it for overlap with the player box, despawns it
// on a hit, and keeps score / lives / game_over.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    spawn_ctrl_if.master (run, player and spawner readback in;
//          spawn_en, despawn, hit, score, lives, game_over out, all registered)
module spawn_ctrl #(
  parameter int HWIDTH   = 11,
  parameter int VWIDTH   = 10,
  parameter int OBJ_W    = 32,
  parameter int OBJ_H    = 32,
  parameter int PLY_W    = 24,
  parameter int PLY_H    = 48,
  parameter int MIN_GAP  = 60,
  parameter int GAP_BITS = 5,
  parameter int LIVES    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  spawn_ctrl_if.master  bus
);

  localparam int          CNT_W     = $clog2(MIN_GAP + (1 << GAP_BITS));
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Box sizes at the extended width so the edge sums cannot overflow.
  localparam logic signed [HWIDTH:0] OBJ_W_X = (HWIDTH+1)'(OBJ_W);
  localparam logic signed [HWIDTH:0] PLY_W_X = (HWIDTH+1)'(PLY_W);
  localparam logic signed [VWIDTH:0] OBJ_H_X = (VWIDTH+1)'(OBJ_H);
  localparam logic signed [VWIDTH:0] PLY_H_X = (VWIDTH+1)'(PLY_H);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_ARM, S_TRACK, S_HIT, S_OVER
  } state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [CNT_W-1:0] gap_cnt;
  logic             spawn_en_q;
  logic             despawn_q;
  logic             hit_q;
  logic             game_over_q;
  logic [15:0]      score_q;
  logic [1:0]       lives_q;

  logic signed [HWIDTH:0] obj_h_x, ply_h_x;
  logic signed [VWIDTH:0] obj_v_x, ply_v_x;
  logic                   collide;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [CNT_W-1:0] gap_load(input logic [15:0] rnd);
    return CNT_W'(MIN_GAP) + CNT_W'(rnd[GAP_BITS-1:0]);
  endfunction

  // Collision: strict inequalities, so touching edges do not count.
  assign obj_h_x = {bus.obj_hoffset[HWIDTH-1], bus.obj_hoffset};
  assign ply_h_x = {bus.player_h[HWIDTH-1],    bus.player_h};
  assign obj_v_x = {bus.obj_voffset[VWIDTH-1], bus.obj_voffset};
  assign ply_v_x = {bus.player_v[VWIDTH-1],    bus.player_v};

  assign collide = bus.obj_active
                && (obj_h_x < ply_h_x + PLY_W_X)
                && (ply_h_x < obj_h_x + OBJ_W_X)
                && (obj_v_x < ply_v_x + PLY_H_X)
                && (ply_v_x < obj_v_x + OBJ_H_X);

  // Free-running Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Launch / track / hit state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      gap_cnt     <= '0;
      spawn_en_q  <= 1'b0;
      despawn_q   <= 1'b0;
      hit_q       <= 1'b0;
      game_over_q <= 1'b0;
      score_q     <= 16'd0;
      lives_q     <= 2'(LIVES);
    end else begin
      hit_q <= 1'b0;
      case (state)
        S_IDLE: begin
          spawn_en_q <= 1'b0;
          despawn_q  <= 1'b0;
          if (bus.run) begin
            gap_cnt <= gap_load(lfsr);
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (!bus.run) begin
            state <= S_IDLE;
          end else if (gap_cnt == '0) begin
            spawn_en_q <= 1'b1;
            state      <= S_ARM;
          end else begin
            gap_cnt <= gap_cnt - CNT_W'(1);
          end
        end
        // run is deliberately ignored here: once en is raised the launch completes.
        S_ARM: begin
          if (bus.obj_active) begin
            spawn_en_q <= 1'b0;
            state      <= S_TRACK;
          end
        end
        // collide already implies obj_active, so a fall is always a pass.
        S_TRACK: begin
          if (collide) begin
            hit_q     <= 1'b1;
            despawn_q <= 1'b1;
            lives_q   <= lives_q - 2'd1;
            state     <= S_HIT;
          end else if (!bus.obj_active) begin
            score_q <= sat_inc16(score_q);
            gap_cnt <= gap_load(lfsr);
            state   <= bus.run ? S_GAP : S_IDLE;
          end
        end
        // No collision checks here: one hit per obstacle.
        S_HIT: begin
          if (!bus.obj_active) begin
            despawn_q <= 1'b0;
            if (lives_q == 2'd0) begin
              game_over_q <= 1'b1;
              state       <= S_OVER;
            end else begin
              gap_cnt <= gap_load(lfsr);
              state   <= bus.run ? S_GAP : S_IDLE;
            end
          end
        end
        S_OVER: begin
          spawn_en_q  <= 1'b0;
          despawn_q   <= 1'b0;
          game_over_q <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.spawn_en  = spawn_en_q;
  assign bus.despawn   = despawn_q;
  assign bus.hit       = hit_q;
  assign bus.score     = score_q;
  assign bus.lives     = lives_q;
  assign bus.game_over = game_over_q;

endmodule
